// File: rtl/alu_2.sv
// alu_2: multi-cycle 8-bit unsigned ALU (add, subtract, multiply).
// Operands A then B arrive serially on inbus. Results leave on the registered
// outbus. A product is shown as its low byte and then its high byte.
// One 8-bit ripple-carry adder does all the arithmetic. Multiply runs as eight
// shift-add steps through that same adder.
module alu_2 (
  input  logic       CLk,
  input  logic       RST,
  input  logic       Begin,
  input  logic [1:0] op,
  input  logic [7:0] inbus,
  output logic [7:0] outbus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_B,
    EXEC,
    MUL,
    OUT_LO,
    OUT_HI,
    DONE
  } state_e;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  state_e      state_q, state_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [1:0]  opr_q, opr_d;
  logic [15:0] prod_q, prod_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  out_q, out_d;

  logic [7:0]  addA;
  logic [7:0]  addB;
  logic        addCin;
  logic [7:0]  addSum;
  logic [8:0]  carry;

  assign outbus = out_q;

  // Adder operand steering.
  // During MUL the adder adds the partial product's high byte and the gated
  // multiplicand. Otherwise it works on A and B, and subtract becomes A + ~B + 1.
  always_comb begin
    addA   = a_q;
    addB   = b_q;
    addCin = 1'b0;
    if (state_q == MUL) begin
      addA = prod_q[15:8];
      addB = b_q[cnt_q] ? a_q : 8'h00;
    end else if (opr_q == OP_SUB) begin
      addB   = ~b_q;
      addCin = 1'b1;
    end
  end

  // The 8-bit ripple-carry adder. carry[8] is the carry out. The accumulator
  // shifts it into its top bit during multiply. Add and subtract discard it.
  assign carry[0] = addCin;
  for (genvar i = 0; i < 8; i++) begin : g_ripple
    assign addSum[i]  = addA[i] ^ addB[i] ^ carry[i];
    assign carry[i+1] = (addA[i] & addB[i]) | (carry[i] & (addA[i] ^ addB[i]));
  end

  // Next-state logic and datapath updates for the sequencer.
  // Every register holds its value unless the current state updates it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    opr_d   = opr_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (Begin) begin
          a_d     = inbus;
          opr_d   = op;
          state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        b_d     = inbus;
        state_d = EXEC;
      end
      EXEC: begin
        case (opr_q)
          OP_ADD, OP_SUB: begin
            out_d   = addSum;
            state_d = DONE;
          end
          OP_MUL: begin
            prod_d  = 16'h0000;
            cnt_d   = 3'd0;
            state_d = MUL;
          end
          OP_RSVD: begin
            out_d   = 8'h00;
            state_d = DONE;
          end
          default: begin
            out_d   = 8'h00;
            state_d = DONE;
          end
        endcase
      end
      MUL: begin
        // {carry, hi, lo} shifts right one place per step. After eight
        // steps, A times bit i of B has landed at weight 2^i.
        prod_d = {carry[8], addSum, prod_q[7:1]};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = OUT_LO;
        end
      end
      OUT_LO: begin
        out_d   = prod_q[7:0];
        state_d = OUT_HI;
      end
      OUT_HI: begin
        out_d   = prod_q[15:8];
        state_d = DONE;
      end
      DONE: begin
        if (!Begin) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. The synchronous reset overrides every state,
  // including a multiply in progress.
  always_ff @(posedge CLk) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      opr_q   <= 2'd0;
      prod_q  <= 16'h0000;
      cnt_q   <= 3'd0;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opr_q   <= opr_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

endmodule

// File: tb/tb_alu_2.sv
// tb_alu_2: scoreboard bench for alu_2.
// Stimulus tasks queue the expected outbus value for each future edge.
// A monitor compares each queued value on the falling edge after its clock edge.
module tb_alu_2;

  logic       CLk = 1'b0;
  logic       RST;
  logic       Begin;
  logic [1:0] op;
  logic [7:0] inbus;
  logic [7:0] outbus;

  alu_2 dut (
    .CLk   (CLk),
    .RST   (RST),
    .Begin (Begin),
    .op    (op),
    .inbus (inbus),
    .outbus(outbus)
  );

  // Free-running clock.
  always #5 CLk = ~CLk;

  typedef struct {
    int         cycle;
    logic [7:0] value;
    string      tag;
  } expT;

  typedef struct {
    logic [1:0] opv;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expLo;
    logic [7:0] expHi;
    int         hold;
    string      tag;
  } vecT;

  expT        sbQ[$];
  vecT        vecs[$];
  int         edgeCnt  = 0;
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] modelOut = 8'h00;

  // Counts rising edges. The scoreboard tags each entry with the edge it belongs to.
  always @(posedge CLk) edgeCnt <= edgeCnt + 1;

  task automatic expectAt(input int cyc, input logic [7:0] v, input string tag);
    expT e;
    e.cycle = cyc;
    e.value = v;
    e.tag   = tag;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput(input expT e);
    checks++;
    if (outbus !== e.value) begin
      failures++;
      $display("[TB] FAIL %s @edge %0d: outbus=0x%02h, expected 0x%02h",
               e.tag, e.cycle, outbus, e.value);
    end
  endtask

  // Monitor: pops each entry that is due after the most recent rising edge.
  initial begin
    forever begin
      @(negedge CLk);
      while (sbQ.size() > 0 && sbQ[0].cycle <= edgeCnt) begin
        expT e;
        e = sbQ.pop_front();
        if (e.cycle < edgeCnt) begin
          checks++;
          failures++;
          $display("[TB] FAIL %s: missed check for edge %0d", e.tag, e.cycle);
        end else begin
          checkOutput(e);
        end
      end
    end
  end

  // Runs one operation. inbus and op are scrambled after they are sampled.
  // Begin stays high for 'hold' edges in DONE, then drops for exactly one edge.
  task automatic applyStimulus(input vecT v);
    int n;
    int doneEdge;
    logic [7:0] last;
    @(negedge CLk);
    n     = edgeCnt;
    Begin = 1'b1;
    op    = v.opv;
    inbus = v.a;
    if (v.opv != 2'd2) begin
      expectAt(n + 3, v.expLo, v.tag);
      last     = v.expLo;
      doneEdge = n + 3;
    end else begin
      for (int k = 3; k <= 11; k++) begin
        expectAt(n + k, modelOut, $sformatf("%s_mulhold", v.tag));
      end
      expectAt(n + 12, v.expLo, $sformatf("%s_lo", v.tag));
      expectAt(n + 13, v.expHi, $sformatf("%s_hi", v.tag));
      last     = v.expHi;
      doneEdge = n + 13;
    end
    for (int k = 1; k <= v.hold; k++) begin
      expectAt(doneEdge + k, last, $sformatf("%s_done", v.tag));
    end
    expectAt(doneEdge + v.hold + 1, last, $sformatf("%s_idle", v.tag));
    @(negedge CLk);
    inbus = v.b;
    op    = ~v.opv;
    @(negedge CLk);
    inbus = 8'h07;
    repeat (doneEdge + v.hold - (n + 2)) @(negedge CLk);
    Begin    = 1'b0;
    modelOut = last;
  endtask

  // Starts 32*25. Reset lands on E7, in the middle of the shift-add.
  task automatic resetMidMul();
    int n;
    @(negedge CLk);
    n     = edgeCnt;
    Begin = 1'b1;
    op    = 2'd2;
    inbus = 8'd32;
    for (int k = 3; k <= 6; k++) begin
      expectAt(n + k, modelOut, "rst_mulhold");
    end
    expectAt(n + 7, 8'h00, "rst_mid_mul");
    expectAt(n + 8, 8'h00, "rst_idle");
    @(negedge CLk);
    inbus = 8'd25;
    repeat (5) @(negedge CLk);
    RST = 1'b1;
    @(negedge CLk);
    RST      = 1'b0;
    Begin    = 1'b0;
    modelOut = 8'h00;
  endtask

  // Watchdog: ends the run if the sequence ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  // Main sequence: reset, directed vectors, a mid-multiply reset, then a drain.
  initial begin
    RST   = 1'b1;
    Begin = 1'b0;
    op    = 2'd0;
    inbus = 8'h00;
    vecs.push_back('{2'd0, 8'd24,  8'd31,  8'h37, 8'h00, 3, "add_24_31"});
    vecs.push_back('{2'd1, 8'd99,  8'd55,  8'h2C, 8'h00, 1, "sub_99_55"});
    vecs.push_back('{2'd1, 8'd5,   8'd10,  8'hFB, 8'h00, 1, "sub_wrap"});
    vecs.push_back('{2'd0, 8'd200, 8'd100, 8'h2C, 8'h00, 1, "add_carry"});
    vecs.push_back('{2'd0, 8'd0,   8'd0,   8'h00, 8'h00, 1, "add_zero"});
    vecs.push_back('{2'd2, 8'd32,  8'd25,  8'h20, 8'h03, 2, "mul_32_25"});
    vecs.push_back('{2'd2, 8'd255, 8'd255, 8'h01, 8'hFE, 1, "mul_ff_ff"});
    vecs.push_back('{2'd1, 8'd0,   8'd1,   8'hFF, 8'h00, 1, "sub_0_1"});
    vecs.push_back('{2'd0, 8'd10,  8'd20,  8'h1E, 8'h00, 1, "add_after_rst"});
    vecs.push_back('{2'd3, 8'd77,  8'd88,  8'h00, 8'h00, 4, "op3"});
    vecs.push_back('{2'd2, 8'd13,  8'd11,  8'h8F, 8'h00, 1, "mul_13_11"});

    @(negedge CLk);
    expectAt(edgeCnt + 1, 8'h00, "reset");
    @(negedge CLk);
    RST = 1'b0;
    expectAt(edgeCnt + 1, 8'h00, "reset_idle");

    foreach (vecs[i]) begin
      if (i == 8) begin
        resetMidMul();
      end
      applyStimulus(vecs[i]);
    end

    for (int k = 0; k < 40 && sbQ.size() > 0; k++) begin
      @(negedge CLk);
    end
    while (sbQ.size() > 0) begin
      expT e;
      e = sbQ.pop_front();
      checks++;
      failures++;
      $display("[TB] FAIL %s: check for edge %0d never reached", e.tag, e.cycle);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
